// File: rtl/rv32imf_mem_arb.sv
// rv32imf_mem_arb: merges N_PORTS requesters onto one memory bus and routes responses back in grant order.
// Latency: request, grant and response routing are combinational (0 cycles); outst_o and err_o update on the next edge.
// Backpressure: bus_gnt_i low locks the selected port until accepted; bus_req_o drops while MAX_OUTST transactions are outstanding.
// Option: define RV32IMF_MEM_ARB_RR_EN for round-robin selection; otherwise fixed priority with port 0 highest.

// In-order storage for the port index of each outstanding transaction.
module rv32imf_mem_arb_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the FIFO and discards stale entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
endmodule

module rv32imf_mem_arb #(
    parameter int N_PORTS   = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_PORTS-1:0]                port_req_i,
    input  logic [N_PORTS-1:0]                port_we_i,
    input  logic [N_PORTS*ADDR_W-1:0]         port_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]         port_wdata_i,
    input  logic [N_PORTS*(DATA_W/8)-1:0]     port_be_i,
    output logic [N_PORTS-1:0]                port_gnt_o,
    output logic [N_PORTS-1:0]                port_rvalid_o,
    output logic [DATA_W-1:0]                 port_rdata_o,
    output logic                              bus_req_o,
    output logic                              bus_we_o,
    output logic [ADDR_W-1:0]                 bus_addr_o,
    output logic [DATA_W-1:0]                 bus_wdata_o,
    output logic [DATA_W/8-1:0]               bus_be_o,
    input  logic                              bus_gnt_i,
    input  logic                              bus_rvalid_i,
    input  logic [DATA_W-1:0]                 bus_rdata_i,
    output logic [$clog2(MAX_OUTST):0]        outst_o,
    output logic                              err_o
);
    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] head_idx;
    logic [CNT_W-1:0] outst;
    logic             accept;
    logic             pop;
    logic             lock_drop;

    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             err_q, err_d;

`ifdef RV32IMF_MEM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;
    int               cand;
`endif

    // Bus request is suppressed while full (even if a response frees a slot this cycle) and during reset.
    assign bus_req_o = (|port_req_i) && (outst < FULL_CNT) && !rst_i;
    assign accept    = bus_req_o && bus_gnt_i;
    // A response with nothing outstanding is dropped and flagged instead of routed.
    assign pop       = bus_rvalid_i && (outst != '0);

    // Port selection: a locked port wins outright; a locked port that withdrew falls through to arbitration.
    always_comb begin
        sel       = '0;
        lock_drop = lock_q && !port_req_i[lock_idx_q];
`ifdef RV32IMF_MEM_ARB_RR_EN
        found     = 1'b0;
        cand      = 0;
`endif
        if (lock_q && !lock_drop) begin
            sel = lock_idx_q;
        end else begin
`ifdef RV32IMF_MEM_ARB_RR_EN
            for (int k = 1; k <= N_PORTS; k++) begin
                cand = (int'(rr_ptr_q) + k) % N_PORTS;
                if (!found && port_req_i[cand]) begin
                    sel   = IDX_W'(cand);
                    found = 1'b1;
                end
            end
`else
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (port_req_i[i]) sel = IDX_W'(i);
            end
`endif
        end
    end

    // Pass the selected port's fields to the bus and fan grant/response strobes back out.
    always_comb begin
        bus_we_o      = 1'b0;
        bus_addr_o    = '0;
        bus_wdata_o   = '0;
        bus_be_o      = '0;
        port_gnt_o    = '0;
        port_rvalid_o = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (sel == IDX_W'(i)) begin
                bus_we_o      = port_we_i[i];
                bus_addr_o    = port_addr_i[i*ADDR_W +: ADDR_W];
                bus_wdata_o   = port_wdata_i[i*DATA_W +: DATA_W];
                bus_be_o      = port_be_i[i*BE_W +: BE_W];
                port_gnt_o[i] = accept;
            end
            if (head_idx == IDX_W'(i)) port_rvalid_o[i] = pop;
        end
    end

    // Next state for the lock, the sticky error flag and the round-robin pointer.
    always_comb begin
        lock_d     = bus_req_o && !bus_gnt_i;
        lock_idx_d = lock_d ? sel : lock_idx_q;
        err_d      = err_q || lock_drop || (bus_rvalid_i && (outst == '0));
`ifdef RV32IMF_MEM_ARB_RR_EN
        rr_ptr_d   = accept ? sel : rr_ptr_q;
`endif
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
`ifdef RV32IMF_MEM_ARB_RR_EN
            rr_ptr_q   <= IDX_W'(N_PORTS - 1);
`endif
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
`ifdef RV32IMF_MEM_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    rv32imf_mem_arb_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTST)
    ) u_route_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (accept),
        .push_dat_i (sel),
        .pop_i      (pop),
        .head_dat_o (head_idx),
        .count_o    (outst)
    );

    assign port_rdata_o = bus_rdata_i;
    assign outst_o      = outst;
    assign err_o        = err_q;
endmodule

// File: tb/tb_rv32imf_mem_arb.sv
module tb_rv32imf_mem_arb;
    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NP-1:0]     port_req_i;
    logic [NP-1:0]     port_we_i;
    logic [NP*AW-1:0]  port_addr_i;
    logic [NP*DW-1:0]  port_wdata_i;
    logic [NP*BW-1:0]  port_be_i;
    logic [NP-1:0]     port_gnt_o;
    logic [NP-1:0]     port_rvalid_o;
    logic [DW-1:0]     port_rdata_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [AW-1:0]     bus_addr_o;
    logic [DW-1:0]     bus_wdata_o;
    logic [BW-1:0]     bus_be_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [DW-1:0]     bus_rdata_i;
    logic [CW-1:0]     outst_o;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    rv32imf_mem_arb #(
        .N_PORTS (NP), .DATA_W (DW), .ADDR_W (AW), .MAX_OUTST (MO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .port_req_i    (port_req_i),
        .port_we_i     (port_we_i),
        .port_addr_i   (port_addr_i),
        .port_wdata_i  (port_wdata_i),
        .port_be_i     (port_be_i),
        .port_gnt_o    (port_gnt_o),
        .port_rvalid_o (port_rvalid_o),
        .port_rdata_o  (port_rdata_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_be_o      (bus_be_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i),
        .outst_o       (outst_o),
        .err_o         (err_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of ports awaiting a response, pending (ungranted) port, error flag, last winner.
    int route_q[$];
    bit held_vld;
    int held;
    bit m_err;
    int last;

    // Values seen in the most recent cycle, for directed scenario checks.
    logic          obs_req;
    logic [NP-1:0] obs_gnt;
    logic [NP-1:0] obs_rv;
    logic [DW-1:0] obs_rdata;
    logic [CW-1:0] obs_outst;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic model_reset();
        route_q.delete();
        held_vld = 1'b0;
        held     = 0;
        m_err    = 1'b0;
        last     = NP - 1;
    endtask

    function automatic int pick_port(input logic [NP-1:0] req);
        if (held_vld && req[held]) return held;
`ifdef RV32IMF_MEM_ARB_RR_EN
        for (int k = 1; k <= NP; k++) if (req[(last + k) % NP]) return (last + k) % NP;
`else
        for (int i = 0; i < NP; i++) if (req[i]) return i;
`endif
        return 0;
    endfunction

    // One bus cycle: drive at the falling edge, check just after, advance the model at the rising edge.
    task automatic step(input logic [NP-1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
        logic          exp_req, acc, pop, err_nx;
        logic [NP-1:0] exp_gnt, exp_rv;
        int            p;
        port_req_i   = req;
        bus_gnt_i    = gnt;
        bus_rvalid_i = rv;
        bus_rdata_i  = rd;
        port_we_i    = NP'($urandom);
        for (int i = 0; i < NP; i++) begin
            port_addr_i[i*AW +: AW]  = $urandom;
            port_wdata_i[i*DW +: DW] = $urandom;
            port_be_i[i*BW +: BW]    = BW'($urandom);
        end
        exp_req = (req != '0) && (route_q.size() < MO);
        p       = pick_port(req);
        acc     = exp_req && gnt;
        exp_gnt = '0;
        if (acc) exp_gnt[p] = 1'b1;
        pop     = rv && (route_q.size() > 0);
        exp_rv  = '0;
        if (pop) exp_rv[route_q[0]] = 1'b1;
        err_nx  = m_err || (held_vld && !req[held]) || (rv && route_q.size() == 0);
        #1;
        obs_req   = bus_req_o;
        obs_gnt   = port_gnt_o;
        obs_rv    = port_rvalid_o;
        obs_rdata = port_rdata_o;
        obs_outst = outst_o;
        chk("outst", 32'(outst_o), route_q.size());
        chk("err", 32'(err_o), 32'(m_err));
        chk("bus_req", 32'(bus_req_o), 32'(exp_req));
        chk("port_gnt", 32'(port_gnt_o), 32'(exp_gnt));
        chk("port_rvalid", 32'(port_rvalid_o), 32'(exp_rv));
        chk("port_rdata", port_rdata_o, rd);
        if (exp_req) begin
            chk("bus_addr", bus_addr_o, port_addr_i[p*AW +: AW]);
            chk("bus_wdata", bus_wdata_o, port_wdata_i[p*DW +: DW]);
            chk("bus_be", 32'(bus_be_o), 32'(port_be_i[p*BW +: BW]));
            chk("bus_we", 32'(bus_we_o), 32'(port_we_i[p]));
        end
        @(posedge clk_i);
        if (pop) void'(route_q.pop_front());
        if (acc) begin
            route_q.push_back(p);
            last = p;
        end
        held_vld = exp_req && !gnt;
        held     = p;
        m_err    = err_nx;
        @(negedge clk_i);
    endtask

    // Reset for one cycle with aggressive inputs; outputs must stay quiet throughout.
    task automatic do_reset();
        rst_i        = 1'b1;
        port_req_i   = '1;
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        #1;
        chk("rst_bus_req", 32'(bus_req_o), 0);
        chk("rst_gnt", 32'(port_gnt_o), 0);
        chk("rst_rvalid", 32'(port_rvalid_o), 0);
        chk("rst_outst", 32'(outst_o), 0);
        chk("rst_err", 32'(err_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i        = 1'b0;
        port_req_i   = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [NP-1:0] r;
        logic [NP-1:0] exp_alt;
        rst_i        = 1'b1;
        port_req_i   = '0;
        port_we_i    = '0;
        port_addr_i  = '0;
        port_wdata_i = '0;
        port_be_i    = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        model_reset();
        @(negedge clk_i);
        do_reset();

        // Both ports request continuously, bus always grants, responses one cycle later.
        for (int c = 0; c < 8; c++) begin
            step(2'b11, 1'b1, route_q.size() > 0, $urandom);
`ifdef RV32IMF_MEM_ARB_RR_EN
            exp_alt = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_alt = 2'b01;
`endif
            chk("alt_gnt", 32'(obs_gnt), 32'(exp_alt));
        end

        // Port 1 stalled by the bus holds the lock against port 0.
        do_reset();
        step(2'b10, 1'b0, 1'b0, 0);
        chk("lock_wait0", 32'(obs_gnt), 0);
        step(2'b11, 1'b0, 1'b0, 0);
        step(2'b11, 1'b0, 1'b0, 0);
        chk("lock_wait2", 32'(obs_gnt), 0);
        step(2'b11, 1'b1, 1'b0, 0);
        chk("lock_gnt_p1", 32'(obs_gnt), 32'(2'b10));
        step(2'b11, 1'b1, 1'b0, 0);
        chk("after_lock_p0", 32'(obs_gnt), 32'(2'b01));
        step(2'b00, 1'b0, 1'b1, 32'h1111_0000);
        step(2'b00, 1'b0, 1'b1, 32'h2222_0000);

        // Fill to MAX_OUTST with no responses, then free one slot.
        do_reset();
        for (int c = 0; c < 6; c++) step(2'b01, 1'b1, 1'b0, 0);
        chk("full_outst", 32'(obs_outst), MO);
        chk("full_req_low", 32'(obs_req), 0);
        step(2'b01, 1'b1, 1'b1, 32'h0bad_cafe);
        chk("full_pop_req_low", 32'(obs_req), 0);
        chk("full_pop_rvalid", 32'(obs_rv), 32'(2'b01));
        step(2'b01, 1'b0, 1'b0, 0);
        chk("after_pop_outst", 32'(obs_outst), MO - 1);
        chk("after_pop_req", 32'(obs_req), 1);
        for (int c = 0; c < MO; c++) step(2'b00, 1'b0, 1'b1, $urandom);

        // In-order response routing: grants 1,0,1 then data A,B,C.
        do_reset();
        step(2'b10, 1'b1, 1'b0, 0);
        step(2'b01, 1'b1, 1'b0, 0);
        step(2'b10, 1'b1, 1'b0, 0);
        step(2'b00, 1'b0, 1'b1, 32'hAAAA_0001);
        chk("route_a", 32'(obs_rv), 32'(2'b10));
        chk("data_a", obs_rdata, 32'hAAAA_0001);
        step(2'b00, 1'b0, 1'b1, 32'hBBBB_0002);
        chk("route_b", 32'(obs_rv), 32'(2'b01));
        chk("data_b", obs_rdata, 32'hBBBB_0002);
        step(2'b00, 1'b0, 1'b1, 32'hCCCC_0003);
        chk("route_c", 32'(obs_rv), 32'(2'b10));
        chk("data_c", obs_rdata, 32'hCCCC_0003);

        // Stray response with nothing outstanding: dropped, error sticks until reset.
        do_reset();
        step(2'b00, 1'b0, 1'b1, 32'hdead_beef);
        chk("stray_no_rvalid", 32'(obs_rv), 0);
        for (int c = 0; c < 3; c++) step(2'b01, 1'b1, 1'b0, 0);
        chk("err_held", 32'(err_o), 1);
        do_reset();

        // A locked port withdrawing its request is a protocol error.
        step(2'b10, 1'b0, 1'b0, 0);
        step(2'b00, 1'b0, 1'b0, 0);
        chk("lock_drop_err", 32'(err_o), 1);
        do_reset();

        // Randomized legal traffic.
        for (int c = 0; c < 400; c++) begin
            r = NP'($urandom_range(0, 3));
            if (held_vld) r[held] = 1'b1;
            step(r, 1'($urandom_range(0, 1)),
                 (route_q.size() > 0) && ($urandom_range(0, 2) != 0), $urandom);
        end

        // Reset mid-stream discards outstanding entries; a late response is then a stray.
        do_reset();
        step(2'b00, 1'b0, 1'b1, $urandom);
        chk("late_rsp_err", 32'(err_o), 1);
        step(2'b00, 1'b0, 1'b0, 0);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv32imf_mem_arb.md
RV32IMF_MEM_ARB -- requirements
Module: rv32imf_mem_arb

Interface
REQ-001 Parameter N_PORTS, default 2, number of requester ports; port 0 data, port 1 instruction; legal range 2..8.
REQ-002 Parameter DATA_W, default 32, data width in bits; multiple of 8.
REQ-003 Parameter ADDR_W, default 32, address width in bits.
REQ-004 Parameter MAX_OUTST, default 4, maximum outstanding bus transactions; power of two, 2..16.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk_i  input  1  clock; all state on rising edge.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 port_req_i  input  N_PORTS  per-port request.
REQ-009 port_we_i  input  N_PORTS  per-port write enable.
REQ-010 port_addr_i / port_wdata_i / port_be_i  input  N_PORTS x ADDR_W / DATA_W / DATA_W/8  packed per-port address, write data, byte enables.
REQ-011 port_gnt_o  output  N_PORTS  per-port grant.
REQ-012 port_rvalid_o  output  N_PORTS  per-port response valid.
REQ-013 port_rdata_o  output  DATA_W  response data, shared by all ports.
REQ-014 bus_req_o, bus_we_o  output  1 each; bus_addr_o, bus_wdata_o, bus_be_o  output  ADDR_W, DATA_W, DATA_W/8  merged bus request.
REQ-015 bus_gnt_i, bus_rvalid_i  input  1 each; bus_rdata_i  input  DATA_W  bus grant, response valid, response data.
REQ-016 outst_o  output  clog2(MAX_OUTST)+1  current outstanding count.
REQ-017 err_o  output  1  sticky protocol-error flag.

Function
REQ-018 The block SHALL merge N_PORTS request/grant/rvalid ports onto one bus; a transaction is accepted in the cycle bus_req_o and bus_gnt_i are both high.
REQ-019 bus_req_o SHALL be high when any port_req_i bit is high and outst_o < MAX_OUTST.
REQ-020 bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o SHALL be the selected port's fields, passed through combinationally.
REQ-021 port_gnt_o[i] SHALL equal bus_gnt_i AND bus_req_o AND (selected port == i); at most one bit is high per cycle.
REQ-022 Lock: if bus_req_o is high and bus_gnt_i is low, the selected port SHALL be held in the following cycle regardless of other requests.
REQ-023 The lock SHALL release on the accepting cycle; a locked port that drops port_req_i SHALL set err_o and release the lock.
REQ-024 On each accepted transaction, the granted port index SHALL be pushed into an in-order routing FIFO of depth MAX_OUTST.
REQ-025 On bus_rvalid_i, the FIFO head SHALL be popped and port_rvalid_o[head] driven high in the same cycle; port_rdata_o = bus_rdata_i combinationally.
REQ-026 bus_rvalid_i with outst_o == 0 SHALL be ignored (no port_rvalid_o) and SHALL set err_o.
REQ-027 Push and pop in the same cycle SHALL leave outst_o unchanged; wrap-around of FIFO pointers modulo MAX_OUTST.
REQ-028 When outst_o == MAX_OUTST, bus_req_o SHALL be low even if bus_rvalid_i pops in that cycle; a request resumes the next cycle.
REQ-029 A response to a transaction SHALL be accepted no earlier than the cycle after its grant; zero-latency responses are a protocol error and are not supported.
REQ-030 err_o SHALL remain high until reset.

Reset
REQ-031 On rst_i high: outst_o = 0, FIFO empty, lock cleared, err_o = 0, port_rvalid_o = 0, round-robin pointer = N_PORTS-1.
REQ-032 While rst_i is high, bus_req_o and port_gnt_o SHALL be low.
REQ-033 Reset mid-operation SHALL discard all outstanding entries; responses arriving after reset deassertion with outst_o == 0 are handled per REQ-026.

Configuration
REQ-034 Macro RV32IMF_MEM_ARB_RR_EN defined: selection is round-robin; the search starts at the last accepted port + 1 (mod N_PORTS), and the pointer updates only on accepted transactions.
REQ-035 Macro RV32IMF_MEM_ARB_RR_EN undefined: fixed priority, lowest requesting index wins; no pointer register.
REQ-036 The lock (REQ-022) SHALL apply in both modes.

Verification
REQ-037 Ports 0,1 request continuously, bus_gnt_i=1, rvalid 1 cycle later: with RR_EN, grants alternate 0,1,0,1; without RR_EN, port 0 is granted every cycle.
REQ-038 Port 1 requests with bus_gnt_i=0 for 3 cycles, port 0 requests in cycle 2: port_gnt_o=2'b10 when bus_gnt_i rises; port 0 is granted afterwards.
REQ-039 MAX_OUTST=4, bus_rvalid_i held low, 6 requests: outst_o reaches 4 and bus_req_o drops; one rvalid gives outst_o=3, and bus_req_o is high the next cycle.
REQ-040 Grants to ports 1,0,1, then three bus_rvalid_i with rdata A,B,C: port_rvalid_o = 10,01,10 with data A,B,C.
REQ-041 bus_rvalid_i with outst_o=0: no port_rvalid_o, err_o=1 and held; rst_i pulse mid-stream returns outst_o=0 and err_o=0.
